// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and counter width for the I/D memory port arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, RSP_I, RSP_D} arb_state_t;

    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating count of D grants taken while fetch waits; at_max forces I through
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic at_max
);

    localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt_q, cnt_d;

    assign at_max = cnt_q == MAX_V;

    // clear wins over increment; the count holds once saturated
    always_comb begin
        cnt_d = clr ? '0 : (inc && !at_max) ? cnt_q + 1'b1 : cnt_q;
    end

    // count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), one transaction in flight
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                fetch_stall
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_i_wait,
    output logic [31:0]         perf_d_xfer,
    output logic                perf_spurious
`endif
);

    arb_state_t state_q, state_d;
    arb_owner_t owner;
    logic       active, act_i, act_d, starve_at_max;

    mem_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (i_gnt || !i_req),
        .inc     (d_gnt && i_req),
        .at_max  (starve_at_max)
    );

    // owner: IDLE arbitrates (D first unless fetch is starved), REQ_x keeps the locked owner
    always_comb begin
        owner  = (state_q == REQ_D || (state_q == IDLE && d_req && !(i_req && starve_at_max))) ? OWN_D : OWN_I;
        active = (state_q == IDLE && (d_req || i_req)) || state_q == REQ_I || state_q == REQ_D;
        act_d  = active && owner == OWN_D;
        act_i  = active && owner == OWN_I;
    end

    // port muxing and handshakes; responses route straight through to the owner
    always_comb begin
        mem_req     = active;
        mem_we      = act_d && d_we;
        mem_be      = act_d ? d_be : act_i ? '1 : '0;
        mem_addr    = act_d ? d_addr : act_i ? i_addr : '0;
        mem_wdata   = act_d ? d_wdata : '0;
        i_gnt       = act_i && mem_gnt;
        d_gnt       = act_d && mem_gnt;
        i_rvalid    = state_q == RSP_I && mem_rvalid;
        d_rvalid    = state_q == RSP_D && mem_rvalid;
        i_rdata     = i_rvalid ? mem_rdata : '0;
        d_rdata     = d_rvalid ? mem_rdata : '0;
        fetch_stall = i_req && !i_gnt;
    end

    // next state: RSP waits for rvalid, otherwise issue toward REQ_x or straight to RSP_x on grant
    always_comb begin
        state_d = (state_q == RSP_I || state_q == RSP_D) ? (mem_rvalid ? IDLE : state_q) :
                  !active         ? IDLE :
                  owner == OWN_D  ? (mem_gnt ? RSP_D : REQ_D) :
                                    (mem_gnt ? RSP_I : REQ_I);
    end

    // state register; reset abandons any in-flight response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_i_wait_q, perf_i_wait_d, perf_d_xfer_q, perf_d_xfer_d;
    logic        perf_spurious_q, perf_spurious_d;

    // wrap-around event counters and a sticky flag for responses nobody is waiting for
    always_comb begin
        perf_i_wait_d   = perf_i_wait_q + {31'd0, fetch_stall};
        perf_d_xfer_d   = perf_d_xfer_q + {31'd0, d_gnt};
        perf_spurious_d = perf_spurious_q || (mem_rvalid && state_q != RSP_I && state_q != RSP_D);
    end

    // performance registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_i_wait_q   <= '0;
            perf_d_xfer_q   <= '0;
            perf_spurious_q <= 1'b0;
        end else begin
            perf_i_wait_q   <= perf_i_wait_d;
            perf_d_xfer_q   <= perf_d_xfer_d;
            perf_spurious_q <= perf_spurious_d;
        end
    end

    assign perf_i_wait   = perf_i_wait_q;
    assign perf_d_xfer   = perf_d_xfer_q;
    assign perf_spurious = perf_spurious_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified instruction/data memory port between the fetch side (I) and the load/store side (D) of the pipelined core.
- Allows one outstanding transaction at a time.
- D normally has priority; a bounded starvation guard forces I through.
- Drives the fetch-stall indication that holds the PC register while fetch is waiting.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- STARVE_MAX, 4, number of consecutive D grants allowed while i_req is pending before I is forced; range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address (PC).
- i_gnt  out  1  fetch request accepted by memory this cycle.
- i_rvalid  out  1  instruction returned.
- i_rdata  out  DATA_W  instruction word.
- d_req  in  1  load/store request.
- d_we  in  1  1 = store.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  load data / store acknowledge.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  request to memory.
- mem_we  out  1  write strobe.
- mem_be  out  DATA_W/8  byte enables; all ones for fetch.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data; 0 for fetch.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  response valid; also asserted for writes.
- mem_rdata  in  DATA_W  response data.
- fetch_stall  out  1  equals i_req && !i_gnt; feeds the PC-hold logic.

Behaviour:
- FSM states: IDLE, REQ_I, REQ_D, RSP_I, RSP_D. Reset state is IDLE.
- Reset values: all outputs 0, starve counter 0, state IDLE.
- IDLE:
  - Owner is selected combinationally: D if d_req && !(i_req && starve==STARVE_MAX); else I if i_req; else none.
  - mem_* is driven from the selected owner in the same cycle (zero-cycle issue).
  - mem_gnt=1 -> matching x_gnt=1 that cycle; next state RSP_x.
  - mem_gnt=0 -> next state REQ_x (owner locked).
- REQ_x:
  - mem_req=1 with the owner's fields.
  - The other requester is not considered.
  - On mem_gnt -> x_gnt=1, next state RSP_x.
- RSP_x:
  - mem_req=0; wait for mem_rvalid.
  - On mem_rvalid: x_rvalid=1 and x_rdata=mem_rdata in the same cycle (combinational route); next state IDLE.
  - The next issue happens in IDLE, so minimum turnaround is 2 cycles per transaction.
- Requester rule: x_req and its fields are held stable from assertion until x_gnt. Dropping a request in REQ_x is illegal and is covered by a bench assertion.
- The non-owner's rvalid is always 0; its rdata is 0.
- Starve counter (4 bits, saturating at STARVE_MAX):
  - +1 on each d_gnt while i_req=1.
  - Cleared on i_gnt, or on any cycle with i_req=0.
- Simultaneous mem_gnt and mem_rvalid in REQ/IDLE cannot occur, because only one transaction is outstanding. mem_rvalid outside RSP_x is spurious and ignored.
- Reset asserted mid-transaction: immediate return to IDLE; the in-flight response is dropped (the memory is reset on the same reset_n).
- fetch_stall is purely combinational. It is high in every cycle where fetch waits, including while D owns the port.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds output ports:
  - perf_i_wait  out  32  count of cycles with fetch_stall=1.
  - perf_d_xfer  out  32  count of d_gnt pulses.
  - perf_spurious  out  1  sticky flag, set on mem_rvalid outside RSP states.
- Counters wrap modulo 2^32; all three clear on reset_n only.
- When not defined: the ports and logic are absent, and arbitration behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [2:0] arb_state_t {IDLE, REQ_I, REQ_D, RSP_I, RSP_D};
  - typedef enum logic {OWN_I, OWN_D} arb_owner_t;
  - localparam STARVE_W = 4.
- One sub-module: mem_arb_starve_ctr (saturating counter with clear/increment and an at_max output).
- FSM and muxing live in the top module.

Test Plan:
- Single fetch: i_req=1, i_addr=0x8000_0000, mem_gnt=1 immediately, mem_rvalid 2 cycles later with 0x0000_0013 -> i_gnt in cycle 0, fetch_stall=0 in cycle 0, i_rvalid with i_rdata=0x13 in cycle 2.
- Contention: i_req and d_req both high in IDLE, d_addr=0x100, mem latency 1 -> D granted first and fetch_stall=1; I granted in the IDLE cycle after d_rvalid.
- Starvation: d_req held high continuously with i_req high, STARVE_MAX=4 -> exactly 4 D grants, then an I grant, then D resumes.
- Gnt wait: mem_gnt held low 3 cycles in REQ_D while i_req rises -> owner stays D, mem_addr stays 0x100, no i_gnt until D completes.
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF; d_rvalid on the write ack.
- Reset in RSP_I: drop reset_n for 1 cycle before mem_rvalid -> outputs 0 and state IDLE; a late mem_rvalid produces no i_rvalid (and sets perf_spurious when MEM_ARB_PERF_EN is defined).
